// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state type and default geometry for the dual-port data memory.
package dmem_pkg;
  localparam int DMEM_DATA_W = 16;
  localparam int DMEM_ADDR_W = 16;
  localparam int DMEM_DEPTH  = 8192;
  typedef enum logic {DM_INIT, DM_RUN} dm_state_e;
endpackage

// File: rtl/dmem_be_merge.sv
// dmem_be_merge: byte-enable merge, merged = (old & ~mask) | (new & mask).
// Ports: old_word/new_word (DATA_W) in, be (DATA_W/8) in, merged (DATA_W) out.
module dmem_be_merge #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0]   old_word,
  input  logic [DATA_W-1:0]   new_word,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   merged
);
  logic [DATA_W-1:0] mask;
  for (genvar i = 0; i < DATA_W / 8; i++) begin : g_mask
    assign mask[8*i+:8] = {8{be[i]}};
  end
  assign merged = (old_word & ~mask) | (new_word & mask);
endmodule

// File: rtl/dmem_dp.sv
// dmem_dp: dual-port data memory (A read/write with byte enables, B read-only), falling-edge clocked.
// Ports: clk, rst_n (async active-low); A: a_addr/a_re/a_we/a_be/a_wdata -> a_rdata/a_rvalid;
// B: b_addr/b_re -> b_rdata/b_rvalid; ready (array accepting requests); err (illegal request pulse).
module dmem_dp import dmem_pkg::*; #(
  parameter int DATA_W         = DMEM_DATA_W,
  parameter int ADDR_W         = DMEM_ADDR_W,
  parameter int DEPTH          = DMEM_DEPTH,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic                a_re,
  input  logic                a_we,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [DATA_W-1:0]   a_wdata,
  output logic [DATA_W-1:0]   a_rdata,
  output logic                a_rvalid,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic                b_re,
  output logic [DATA_W-1:0]   b_rdata,
  output logic                b_rvalid,
  output logic                ready,
  output logic                err
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [DATA_W-1:0] mem [DEPTH];
  dm_state_e state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d, mem_waddr;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d, merged, mem_wdata;
  logic a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d, err_q, err_d;
  logic run, clearing, a_ok, b_ok, a_wr, b_hit, mem_we;
  logic [IW-1:0] a_idx, b_idx;
  assign a_idx = a_addr[IW-1:0];
  assign b_idx = b_addr[IW-1:0];
  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  assign a_ok = {1'b0, a_addr} < (ADDR_W+1)'(DEPTH);
  assign b_ok = {1'b0, b_addr} < (ADDR_W+1)'(DEPTH);
  // Single merge feeds both the array write and the write-first bypass to port B.
  dmem_be_merge #(.DATA_W(DATA_W)) u_merge (
    .old_word(mem[a_idx]),
    .new_word(a_wdata),
    .be      (a_be),
    .merged  (merged)
  );
  always_comb begin
    run        = state_q == DM_RUN;
    clearing   = state_q == DM_INIT && CLEAR_ON_RESET;
    a_wr       = run && a_we && !a_re && a_ok;
    b_hit      = a_wr && b_ok && a_addr == b_addr;
    state_d    = (state_q == DM_INIT && (!CLEAR_ON_RESET || cnt_q == IW'(DEPTH - 1))) ? DM_RUN : state_q;
    cnt_d      = clearing ? cnt_q + IW'(1) : cnt_q;
    mem_we     = a_wr || clearing;
    mem_waddr  = run ? a_idx : cnt_q;
    mem_wdata  = run ? merged : '0;
    a_rvalid_d = run && a_re && !a_we;
    b_rvalid_d = run && b_re;
    a_rdata_d  = !a_rvalid_d ? a_rdata_q : a_ok ? mem[a_idx] : '0;
    b_rdata_d  = !b_rvalid_d ? b_rdata_q : !b_ok ? '0 : b_hit ? merged : mem[b_idx];
    err_d      = run && ((a_re && a_we) || ((a_re || a_we) && !a_ok) || (b_re && !b_ok));
  end
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DM_INIT;
      cnt_q      <= '0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      err_q      <= err_d;
    end
  end
  // Array is never reset; zero-fill happens only through INIT.
  always_ff @(negedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign err      = err_q;
  assign ready    = state_q == DM_RUN;
endmodule

// File: tb/tb_dmem_dp.sv
// tb_dmem_dp: randomized self-checking bench for dmem_dp against a word-array reference model.
module tb_dmem_dp;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int D  = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic a_re = 1'b0, a_we = 1'b0, b_re = 1'b0;
  logic [DW/8-1:0] a_be = '0;
  logic [DW-1:0] a_wdata = '0;
  logic [DW-1:0] a_rdata, b_rdata, c_a_rdata, c_b_rdata;
  logic a_rvalid, b_rvalid, ready, err, c_a_rvalid, c_b_rvalid, c_ready, c_err;
  int checks = 0;
  int failures = 0;
  logic [DW-1:0] m [D];
  bit m_ready;
  int left;
  logic [DW-1:0] e_ard, e_brd;
  bit e_arv, e_brv, e_err;
  dmem_dp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .a_addr(a_addr), .a_re(a_re), .a_we(a_we), .a_be(a_be),
    .a_wdata(a_wdata), .a_rdata(a_rdata), .a_rvalid(a_rvalid), .b_addr(b_addr), .b_re(b_re),
    .b_rdata(b_rdata), .b_rvalid(b_rvalid), .ready(ready), .err(err)
  );
  dmem_dp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D), .CLEAR_ON_RESET(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .a_addr(a_addr), .a_re(a_re), .a_we(a_we), .a_be(a_be),
    .a_wdata(a_wdata), .a_rdata(c_a_rdata), .a_rvalid(c_a_rvalid), .b_addr(b_addr), .b_re(b_re),
    .b_rdata(c_b_rdata), .b_rvalid(c_b_rvalid), .ready(c_ready), .err(c_err)
  );
  always #5 clk = ~clk;
  task automatic idle();
    a_re = 0; a_we = 0; b_re = 0; a_be = '0; a_wdata = '0; a_addr = '0; b_addr = '0;
  endtask
  task automatic mreset();
    m_ready = 0; left = D; e_ard = '0; e_brd = '0; e_arv = 0; e_brv = 0; e_err = 0;
  endtask
  // Predict the effect of the current inputs at the next falling edge, then advance past it.
  task automatic tick();
    int ai, bi;
    bit aok, bok;
    ai = int'(a_addr); bi = int'(b_addr);
    aok = ai < D; bok = bi < D;
    e_arv = 0; e_brv = 0; e_err = 0;
    if (m_ready) begin
      e_err = (a_re && a_we) || ((a_re || a_we) && !aok) || (b_re && !bok);
      if (a_re && !a_we) begin e_arv = 1; e_ard = aok ? m[ai] : '0; end
      if (a_we && !a_re && aok)
        for (int i = 0; i < DW / 8; i++) if (a_be[i]) m[ai][8*i+:8] = a_wdata[8*i+:8];
      if (b_re) begin e_brv = 1; e_brd = bok ? m[bi] : '0; end
    end else if (left > 0) begin
      m[D-left] = '0;
      left--;
      if (left == 0) m_ready = 1;
    end
    @(negedge clk); #1;
  endtask
  task automatic test_reset();
    idle();
    #2 rst_n = 0; mreset(); #1;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
    checks++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b%b exp=00", a_rvalid, b_rvalid); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (a_rdata !== '0 || b_rdata !== '0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=0000/0000", a_rdata, b_rdata); end
    checks++; if (c_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_noclear got=%b exp=0", c_ready); end
    #2 rst_n = 1;
  endtask
  task automatic test_init();
    int n = 0;
    while (ready !== 1'b1 && n < 40) begin
      tick(); n++;
      if (n == 1) begin
        checks++; if (c_ready !== 1'b1) begin failures++; $display("FAIL noclear_ready got=%b exp=1", c_ready); end
      end
    end
    checks++; if (n != D) begin failures++; $display("FAIL init_edges got=%0d exp=%0d", n, D); end
    for (int i = 0; i < D; i++) begin
      a_re = 1; a_addr = AW'(i); b_re = 1; b_addr = AW'(D - 1 - i);
      tick();
      checks++; if (a_rvalid !== 1'b1 || a_rdata !== '0) begin failures++; $display("FAIL clear_a[%0d] got=%b/%h exp=1/0000", i, a_rvalid, a_rdata); end
      checks++; if (b_rvalid !== 1'b1 || b_rdata !== '0) begin failures++; $display("FAIL clear_b[%0d] got=%b/%h exp=1/0000", D - 1 - i, b_rvalid, b_rdata); end
    end
    idle(); tick();
    checks++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin failures++; $display("FAIL rvalid_pulse got=%b%b exp=00", a_rvalid, b_rvalid); end
  endtask
  task automatic test_be();
    idle(); a_we = 1; a_addr = 5; a_wdata = 16'hABCD; a_be = 2'b11; tick();
    a_wdata = 16'h0012; a_be = 2'b01; tick();
    idle(); a_we = 1; a_addr = 5; a_wdata = 16'hFFFF; a_be = 2'b00; tick();
    idle(); a_re = 1; a_addr = 5; tick();
    checks++; if (a_rvalid !== 1'b1 || a_rdata !== 16'hAB12) begin failures++; $display("FAIL be_merge got=%b/%h exp=1/ab12", a_rvalid, a_rdata); end
    checks++; if (a_rdata !== e_ard) begin failures++; $display("FAIL be_model got=%h exp=%h", a_rdata, e_ard); end
    idle(); tick();
    checks++; if (a_rdata !== 16'hAB12) begin failures++; $display("FAIL rdata_hold got=%h exp=ab12", a_rdata); end
  endtask
  task automatic test_collision();
    idle(); a_we = 1; a_addr = 3; a_wdata = 16'h1234; a_be = 2'b11; b_re = 1; b_addr = 3; tick();
    checks++; if (b_rvalid !== 1'b1 || b_rdata !== 16'h1234) begin failures++; $display("FAIL collide_full got=%b/%h exp=1/1234", b_rvalid, b_rdata); end
    checks++; if (err !== 1'b0 || a_rvalid !== 1'b0) begin failures++; $display("FAIL collide_flags got=err%b arv%b exp=00", err, a_rvalid); end
    a_wdata = 16'hAA00; a_be = 2'b10; tick();
    checks++; if (b_rdata !== 16'hAA34) begin failures++; $display("FAIL collide_partial got=%h exp=aa34", b_rdata); end
    idle(); a_re = 1; a_addr = 3; b_re = 1; b_addr = 3; tick();
    checks++; if (a_rdata !== 16'hAA34 || b_rdata !== 16'hAA34 || !a_rvalid || !b_rvalid) begin failures++; $display("FAIL dual_read got=%h/%h exp=aa34/aa34", a_rdata, b_rdata); end
  endtask
  task automatic test_errors();
    idle(); a_we = 1; a_addr = 2; a_wdata = 16'h2222; a_be = 2'b11; tick();
    a_re = 1; a_wdata = 16'hFFFF; tick();
    checks++; if (err !== 1'b1 || a_rvalid !== 1'b0) begin failures++; $display("FAIL rw_conflict got=err%b arv%b exp=10", err, a_rvalid); end
    idle(); tick();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_pulse got=%b exp=0", err); end
    a_re = 1; a_addr = 2; tick();
    checks++; if (a_rdata !== 16'h2222) begin failures++; $display("FAIL conflict_nowrite got=%h exp=2222", a_rdata); end
    idle(); b_re = 1; b_addr = AW'(D); tick();
    checks++; if (err !== 1'b1 || b_rvalid !== 1'b1 || b_rdata !== '0) begin failures++; $display("FAIL b_oob got=err%b brv%b %h exp=1 1 0000", err, b_rvalid, b_rdata); end
    idle(); a_re = 1; a_addr = 20; tick();
    checks++; if (err !== 1'b1 || a_rvalid !== 1'b1 || a_rdata !== '0) begin failures++; $display("FAIL a_oob got=err%b arv%b %h exp=1 1 0000", err, a_rvalid, a_rdata); end
    idle(); tick();
  endtask
  task automatic test_reset_mid_init();
    int n = 0;
    a_re = 1; a_addr = 2; tick(); idle();
    rst_n = 0; mreset(); #1;
    checks++; if (ready !== 1'b0 || a_rdata !== '0) begin failures++; $display("FAIL reset_run got=%b/%h exp=0/0000", ready, a_rdata); end
    #2 rst_n = 1;
    for (int i = 0; i < 7; i++) tick();
    rst_n = 0; mreset(); #1;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_init got=%b exp=0", ready); end
    #2 rst_n = 1;
    while (ready !== 1'b1 && n < 40) begin tick(); n++; end
    checks++; if (n != D) begin failures++; $display("FAIL restart_edges got=%0d exp=%0d", n, D); end
  endtask
  task automatic test_not_ready();
    int n = 0;
    int bad = 0;
    #2 rst_n = 0; mreset(); #1; #2 rst_n = 1;
    while (ready !== 1'b1 && n < 40) begin
      a_we = 1; a_re = 1'($urandom); a_addr = AW'($urandom_range(0, 3)); a_be = 2'b11;
      a_wdata = DW'($urandom_range(1, 16'hFFFF)); b_re = 1; b_addr = a_addr;
      tick(); n++;
      if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0 || err !== 1'b0) bad++;
    end
    idle();
    checks++; if (bad != 0 || n != D) begin failures++; $display("FAIL not_ready got=%0d responses in %0d edges exp=0 in %0d", bad, n, D); end
    for (int i = 0; i < 4; i++) begin
      a_re = 1; a_addr = AW'(i); tick();
      checks++; if (a_rdata !== '0) begin failures++; $display("FAIL not_ready_mem[%0d] got=%h exp=0000", i, a_rdata); end
    end
    idle();
  endtask
  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      a_re = ($urandom_range(0, 2) == 0); a_we = ($urandom_range(0, 1) == 0); b_re = 1'($urandom);
      a_addr = AW'($urandom_range(0, 19)); b_addr = ($urandom_range(0, 2) == 0) ? a_addr : AW'($urandom_range(0, 19));
      a_be = 2'($urandom); a_wdata = DW'($urandom);
      tick();
      checks++; if (a_rvalid !== e_arv || a_rdata !== e_ard) begin failures++; $display("FAIL rnd_a[%0d] got=%b/%h exp=%b/%h", k, a_rvalid, a_rdata, e_arv, e_ard); end
      checks++; if (b_rvalid !== e_brv || b_rdata !== e_brd) begin failures++; $display("FAIL rnd_b[%0d] got=%b/%h exp=%b/%h", k, b_rvalid, b_rdata, e_brv, e_brd); end
      checks++; if (err !== e_err || ready !== 1'b1) begin failures++; $display("FAIL rnd_flags[%0d] got=err%b rdy%b exp=err%b rdy1", k, err, ready, e_err); end
    end
    idle();
  endtask
  initial begin
    test_reset();
    test_init();
    test_be();
    test_collision();
    test_errors();
    test_reset_mid_init();
    test_not_ready();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_dp.md
DMEM_DP -- requirements
Module: dmem_dp

Interface
REQ-001 Parameter DATA_W, default 16: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 16: address width in bits.
REQ-003 Parameter DEPTH, default 8192: number of words; SHALL satisfy DEPTH <= 2**ADDR_W.
REQ-004 Parameter CLEAR_ON_RESET, default 1: 1 = zero-fill the array after reset; 0 = skip zero-fill.
REQ-005 Port clk  input  1: single clock; all state SHALL update on the falling edge.
REQ-006 Port rst_n  input  1: asynchronous, active-low reset.
REQ-007 Port a_addr  input  ADDR_W: port A word address.
REQ-008 Port a_re  input  1: port A read request.
REQ-009 Port a_we  input  1: port A write request.
REQ-010 Port a_be  input  DATA_W/8: port A byte enables; bit i enables bits [8i+7:8i].
REQ-011 Port a_wdata  input  DATA_W: port A write data.
REQ-012 Port a_rdata  output  DATA_W: port A read data.
REQ-013 Port a_rvalid  output  1: one-cycle pulse; a_rdata is valid.
REQ-014 Port b_addr  input  ADDR_W: port B read-only word address.
REQ-015 Port b_re  input  1: port B read request.
REQ-016 Port b_rdata  output  DATA_W: port B read data.
REQ-017 Port b_rvalid  output  1: one-cycle pulse; b_rdata is valid.
REQ-018 Port ready  output  1: high when the array accepts requests.
REQ-019 Port err  output  1: one-cycle pulse flagging an illegal request.

Function
REQ-020 Two-state FSM: INIT and RUN; ready SHALL be 1 only in RUN.
REQ-021 INIT: clear counter starting at 0; one word zeroed per falling edge; move to RUN on the edge that writes DEPTH-1; DEPTH cycles total.
REQ-022 With CLEAR_ON_RESET=0, the FSM SHALL enter RUN on the first falling edge after reset release.
REQ-023 While ready=0, requests SHALL be ignored: no array access, no rvalid, no err.
REQ-024 Read latency: requests sampled on falling edge N; rdata and rvalid SHALL be driven from edge N; rvalid high for exactly one cycle.
REQ-025 Port A write, a_we=1 and a_re=0: update only the bytes with a_be set; a_be=0 SHALL be a legal no-op.
REQ-026 Port A with a_re=1 and a_we=1 SHALL perform no access, SHALL pulse err, and SHALL NOT pulse a_rvalid.
REQ-027 Address >= DEPTH on a requesting port SHALL perform no access and SHALL pulse err; a read SHALL still pulse rvalid with rdata=0.
REQ-028 Same-edge collision, port A write and port B read to the same address: b_rdata SHALL return the merged post-write word (write-first).
REQ-029 Port A read and port B read in the same cycle, including the same address: both SHALL be served independently.
REQ-030 a_rdata and b_rdata SHALL hold their last value when rvalid is low.

Reset
REQ-031 Assertion of rst_n=0 SHALL immediately force: FSM to INIT (CLEAR_ON_RESET=1) or a pre-RUN wait state (0), clear counter=0, ready=0, a_rvalid=0, b_rvalid=0, err=0, a_rdata=0, b_rdata=0.
REQ-032 Reset during INIT SHALL restart the clear from address 0.
REQ-033 Array contents SHALL NOT be reset directly; zero-fill SHALL occur only through INIT.

Structure
REQ-034 A shared package dmem_pkg SHALL hold the FSM state enum (DM_INIT, DM_RUN) and the default DATA_W, ADDR_W and DEPTH constants.
REQ-035 Byte-enable merge, (old & ~mask) | (new & mask), SHALL be one sub-module, dmem_be_merge, used by both the array write and the collision bypass.

Verification
REQ-036 CLEAR_ON_RESET=1, DEPTH=16: release reset -> ready rises after 16 falling edges; reading all 16 addresses returns 0.
REQ-037 Write a_addr=5, a_wdata=16'hABCD, a_be=2'b11, then write a_be=2'b01 with a_wdata=16'h0012 -> a read of 5 returns 16'hAB12.
REQ-038 Same edge: A writes 16'h1234 to address 3, B reads address 3 -> b_rdata=16'h1234 with b_rvalid=1.
REQ-039 a_re=a_we=1 at address 2 -> err=1 for one cycle, a_rvalid=0, address 2 unchanged; b_re at b_addr=DEPTH -> err=1, b_rvalid=1, b_rdata=0.
REQ-040 Assert rst_n mid-INIT at counter=7 -> ready=0 at once; after release, ready rises DEPTH cycles later.
REQ-041 Requests issued while ready=0 -> no rvalid, no err, array unchanged.
